// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock bank and its unlock FSM.
package reglk_pkg;

  typedef enum logic [1:0] {
    ST_OPEN        = 2'd0,
    ST_LOCKED      = 2'd1,
    ST_UNLOCK_WAIT = 2'd2
  } reglk_state_e;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } reglk_rsp_t;

  localparam int          STATUS_IDX   = 30;
  localparam int          CTRL_IDX     = 31;
  localparam logic [31:0] DEF_LOCK_KEY = 32'hA5C3_0001;

  function automatic int num_words(input int nb, input int lk);
    return (nb * lk + 31) / 32;
  endfunction

endpackage

// File: rtl/reglk_unlock_fsm.sv
// Global OPEN/LOCKED/UNLOCK_WAIT state with the timed JTAG unlock counter.
module reglk_unlock_fsm import reglk_pkg::*; #(
  parameter int UNLOCK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       soft_rst_i,
  input  logic       lock_req,
  input  logic       jtag_unlock,
  input  logic       fault,
  output logic [1:0] state,
  output logic       locked
);

  localparam int CW   = $clog2(UNLOCK_CYCLES + 1);
  // Entry into UNLOCK_WAIT already counts as the first high cycle.
  localparam int LAST = (UNLOCK_CYCLES > 1) ? UNLOCK_CYCLES - 2 : 0;
  localparam bit DIRECT = (UNLOCK_CYCLES == 1);

  reglk_state_e  st;
  logic [CW-1:0] cnt;

  assign state = st;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st     <= ST_OPEN;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (soft_rst_i) begin
      st     <= ST_OPEN;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (fault) begin
      st     <= ST_LOCKED;
      cnt    <= '0;
      locked <= 1'b1;
    end else begin
      case (st)
        ST_OPEN: begin
          if (lock_req) begin
            st     <= ST_LOCKED;
            locked <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (jtag_unlock) begin
            cnt <= '0;
            if (DIRECT) begin
              st     <= ST_OPEN;
              locked <= 1'b0;
            end else begin
              st <= ST_UNLOCK_WAIT;
            end
          end
        end
        ST_UNLOCK_WAIT: begin
          if (!jtag_unlock) begin
            st  <= ST_LOCKED;
            cnt <= '0;
          end else if (cnt == CW'(LAST)) begin
            st     <= ST_OPEN;
            cnt    <= '0;
            locked <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st     <= ST_LOCKED;
          cnt    <= '0;
          locked <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reglk_bank.sv
// Register-lock bank: lock-word storage, bus decode, registered response.
// Optional per-word parity with sticky fault under `REGLK_PARITY_EN.
module reglk_bank import reglk_pkg::*; #(
  parameter int          NB_PERIPHERALS = 14,
  parameter int          LK_BITS        = 8,
  parameter int          UNLOCK_CYCLES  = 16,
  parameter logic [31:0] LOCK_KEY       = DEF_LOCK_KEY
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             soft_rst_i,
  input  logic                             jtag_unlock_i,
  input  logic                             acct_ok_i,
  input  logic                             req_i,
  input  logic                             we_i,
  input  logic [7:0]                       addr_i,
  input  logic [31:0]                      wdata_i,
  output logic                             rvalid_o,
  output logic [31:0]                      rdata_o,
  output logic                             err_o,
  output logic [NB_PERIPHERALS*LK_BITS-1:0] reglk_o,
  output logic                             locked_o
);

  localparam int TOTAL     = NB_PERIPHERALS * LK_BITS;
  localparam int NUM_WORDS = num_words(NB_PERIPHERALS, LK_BITS);

  logic [NUM_WORDS-1:0][31:0] words;
  logic [NUM_WORDS-1:0][31:0] mask;
  logic [NUM_WORDS*32-1:0]    flat;
  logic [4:0]                 idx;
  logic [31:0]                rd_word, sel_mask, wdata_m;
  logic [1:0]                 state;
  logic                       fault, is_open, wr_en, lock_req;
  reglk_rsp_t                 rsp_d, rsp_q;
  logic                       unused;

  assign idx     = addr_i[7:3];
  assign flat    = words;
  assign is_open = (state == ST_OPEN) && !fault;
  assign wdata_m = wdata_i & sel_mask;
  assign unused  = ^{addr_i[2:0], flat};

  // Bits past the last peripheral are never stored, so they read back 0.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_mask
    localparam int VALID = (TOTAL - w * 32 >= 32) ? 32 : TOTAL - w * 32;
    assign mask[w] = (VALID >= 32) ? '1 : 32'((64'd1 << VALID) - 64'd1);
  end

  always_comb begin
    rd_word  = '0;
    sel_mask = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (int'(idx) == w) begin
        rd_word  = words[w];
        sel_mask = mask[w];
      end
    end
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.vld = req_i;
    wr_en     = 1'b0;
    lock_req  = 1'b0;
    if (req_i) begin
      if (!acct_ok_i) begin
        rsp_d.err = 1'b1;
      end else if (int'(idx) < NUM_WORDS) begin
        if (we_i) begin
          if (is_open) wr_en = 1'b1;
          else         rsp_d.err = 1'b1;
        end else if (is_open) begin
          rsp_d.data = rd_word;
        end
      end else if (idx == 5'(STATUS_IDX)) begin
        if (we_i) rsp_d.err  = 1'b1;
        else      rsp_d.data = {29'd0, fault, state};
      end else if (idx == 5'(CTRL_IDX)) begin
        if (we_i && is_open && wdata_i == LOCK_KEY) lock_req = 1'b1;
        else                                         rsp_d.err = 1'b1;
      end else begin
        rsp_d.err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         words <= '0;
    else if (soft_rst_i) words <= '0;
    else if (wr_en) begin
      for (int w = 0; w < NUM_WORDS; w++)
        if (int'(idx) == w) words[w] <= wdata_m;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         rsp_q <= '0;
    else if (soft_rst_i) rsp_q <= '0;
    else                 rsp_q <= rsp_d;
  end

`ifdef REGLK_PARITY_EN
  logic [NUM_WORDS-1:0] par;
  logic                 fault_q, mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) mismatch |= (^words[w]) ^ par[w];
  end

  // Fault is sticky until a hard or soft reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par     <= '0;
      fault_q <= 1'b0;
    end else if (soft_rst_i) begin
      par     <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_q | mismatch;
      if (wr_en) begin
        for (int w = 0; w < NUM_WORDS; w++)
          if (int'(idx) == w) par[w] <= ^wdata_m;
      end
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  reglk_unlock_fsm #(.UNLOCK_CYCLES(UNLOCK_CYCLES)) u_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .soft_rst_i  (soft_rst_i),
    .lock_req    (lock_req),
    .jtag_unlock (jtag_unlock_i),
    .fault       (fault),
    .state       (state),
    .locked      (locked_o)
  );

  assign rvalid_o = rsp_q.vld;
  assign err_o    = rsp_q.err;
  assign rdata_o  = rsp_q.data;
  assign reglk_o  = fault ? '1 : flat[TOTAL-1:0];

endmodule

// File: tb/tb_reglk_bank.sv
// Scoreboard bench for reglk_bank: bus responses are queued at issue and checked by a monitor.
module tb_reglk_bank;

  localparam logic [31:0] KEY = 32'hA5C3_0001;

  logic         clk = 1'b0;
  logic         rst_n, soft_rst, jtag, acct_ok, req, we;
  logic [7:0]   addr;
  logic [31:0]  wdata, rdata;
  logic         rvalid, err, locked;
  logic [111:0] reglk;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  string       nm_q[$];

  reglk_bank dut (
    .clk_i(clk), .rst_ni(rst_n), .soft_rst_i(soft_rst), .jtag_unlock_i(jtag),
    .acct_ok_i(acct_ok), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .reglk_o(reglk), .locked_o(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit w, input int i, input logic [31:0] d,
                     input bit e_err, input logic [31:0] e_data, input string nm);
    exp_q.push_back({e_err, e_data});
    nm_q.push_back(nm);
    req = 1'b1; we = w; addr = {i[4:0], 3'b000}; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic hold_jtag(input int n);
    jtag = 1'b1;
    repeat (n) tick();
    jtag = 1'b0;
  endtask

  // Monitor: every response seen pops one expectation.
  initial begin
    logic [32:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          nm = nm_q.pop_front();
          check({nm, "_err"}, err, e[32]);
          check({nm, "_rdata"}, rdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; soft_rst = 1'b0; jtag = 1'b0; acct_ok = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reglk", reglk, 0);
    check("rst_locked", locked, 0);
    check("rst_rvalid", rvalid, 0);
    rst_n = 1'b1;
    tick();
    bus(0, 30, 0, 0, 0, "rst_status");

    // 1: open writes, including the partially mapped last word
    bus(1, 0, 32'hDEAD_BEEF, 0, 0, "wr_idx0");
    check("reglk_w0", reglk[31:0], 32'hDEAD_BEEF);
    bus(0, 0, 0, 0, 32'hDEAD_BEEF, "rd_idx0");
    bus(1, 3, 32'hFFFF_FFFF, 0, 0, "wr_idx3");
    check("reglk_w3", reglk[111:96], 16'hFFFF);
    bus(0, 3, 0, 0, 32'h0000_FFFF, "rd_idx3_masked");

    // 2: lock, then gated access
    bus(1, 31, 32'h1, 1, 0, "ctrl_badkey");
    check("badkey_locked", locked, 0);
    bus(1, 31, KEY, 0, 0, "ctrl_key");
    check("key_locked", locked, 1);
    bus(1, 1, 32'h1234, 1, 0, "wr_idx1_locked");
    bus(0, 0, 0, 0, 0, "rd_idx0_locked");
    bus(0, 30, 0, 0, 1, "status_locked");
    check("locked_w0_kept", reglk[31:0], 32'hDEAD_BEEF);
    check("locked_w1_clean", reglk[63:32], 0);

    // 3: 16-cycle unlock; STATUS shows UNLOCK_WAIT mid-hold
    jtag = 1'b1;
    repeat (4) tick();
    bus(0, 30, 0, 0, 2, "status_uwait");
    repeat (10) tick();
    check("hold15_locked", locked, 1);
    tick();
    jtag = 1'b0;
    check("hold16_open", locked, 0);
    bus(0, 30, 0, 0, 0, "status_open");
    bus(1, 1, 32'h1234, 0, 0, "wr_idx1_open");
    bus(0, 1, 0, 0, 32'h1234, "rd_idx1");

    // 4: aborted hold restarts the count; write on the unlocking edge is rejected
    bus(1, 31, KEY, 0, 0, "relock");
    hold_jtag(10);
    tick();
    check("abort_locked", locked, 1);
    bus(0, 30, 0, 0, 1, "status_abort");
    jtag = 1'b1;
    repeat (15) tick();
    check("rehold15_locked", locked, 1);
    bus(1, 2, 32'h55, 1, 0, "wr_unlock_edge");
    jtag = 1'b0;
    check("rehold16_open", locked, 0);
    bus(0, 2, 0, 0, 0, "rd_idx2_unchanged");

    // lock key and jtag together: lock only, unlock starts next cycle
    jtag = 1'b1;
    bus(1, 31, KEY, 0, 0, "key_with_jtag");
    bus(0, 30, 0, 0, 1, "status_after_key");
    bus(0, 30, 0, 0, 2, "status_uwait2");
    jtag = 1'b0;
    tick();
    hold_jtag(16);
    check("open_again", locked, 0);

    // 5: access-control denial and unmapped index
    acct_ok = 1'b0;
    bus(1, 0, 32'h0, 1, 0, "wr_acct_denied");
    acct_ok = 1'b1;
    bus(0, 0, 0, 0, 32'hDEAD_BEEF, "rd_idx0_kept");
    bus(0, 20, 0, 1, 0, "rd_unmapped");

    // 6: soft reset while locked, then async reset mid-wait
    bus(1, 31, KEY, 0, 0, "lock_soft");
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("soft_reglk", reglk, 0);
    check("soft_locked", locked, 0);
    bus(0, 30, 0, 0, 0, "status_soft");
    bus(1, 0, 32'h77, 0, 0, "wr_idx0_pre_rst");
    bus(1, 31, KEY, 0, 0, "lock_pre_rst");
    jtag = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_reglk", reglk, 0);
    rst_n = 1'b1;
    jtag = 1'b0;
    tick();
    bus(0, 30, 0, 0, 0, "status_async");

`ifdef REGLK_PARITY_EN
    begin
      logic [3:0][31:0] flip;
      bus(1, 0, 32'h1, 0, 0, "wr_par");
      flip = dut.words;
      flip[0][0] = ~flip[0][0];
      force dut.words = flip;
      tick();
      release dut.words;
      tick();
      check("fault_reglk", reglk, {112{1'b1}});
      bus(0, 30, 0, 0, 5, "status_fault");
      hold_jtag(20);
      check("fault_locked", locked, 1);
      bus(0, 30, 0, 0, 5, "status_fault2");
    end
`endif

    repeat (3) tick();
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
